maze_run_sequencer: RTL and testbench

Top-level controller for the 10x10 maze solver. It launches the BFS solver, supervises it with a watchdog, then replays the returned path to a downstream consumer (motor driver or display walker) one move at a time over a valid/ready handshake. While replaying, it tracks the runner position and checks every move against the maze bounds and wall map.

---
 rtl/maze_pkg.sv | 31 +++
 rtl/maze_run_sequencer_move_checker.sv | 33 +++
 rtl/maze_run_sequencer.sv | 160 ++++++++++++++++
 tb/tb_maze_run_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants and types for the maze runner: move encodings, grid
// geometry, failure codes and the run sequencer state encoding.
package maze_pkg;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam int GRID_W   = 10;
  localparam int CELLS    = 100;
  localparam int MAX_PATH = 99;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_NO_PATH = 2'd1,
    FC_TIMEOUT = 2'd2,
    FC_ILLEGAL = 2'd3
  } fail_code_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_SOLVE  = 3'd2,
    S_PLAY   = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5,
    S_FAIL   = 3'd6
  } seq_state_t;

endpackage

// File: rtl/maze_run_sequencer_move_checker.sv
// Combinational move legality: rejects non-one-hot directions, moves off the
// grid edge and moves into a wall; also returns the target row/col.
module move_checker
  import maze_pkg::*;
(
  input  logic [3:0] row,
  input  logic [3:0] col,
  input  logic [3:0] dir,
  input  logic       maze [0:CELLS-1],
  output logic       legal,
  output logic [3:0] next_row,
  output logic [3:0] next_col
);

  logic       in_bounds;
  logic [6:0] target;

  always_comb begin
    next_row  = row;
    next_col  = col;
    in_bounds = 1'b0;
    case (dir)
      DIR_UP:    if (row != 4'd0) begin in_bounds = 1'b1; next_row = row - 4'd1; end
      DIR_DOWN:  if (row != 4'(GRID_W - 1)) begin in_bounds = 1'b1; next_row = row + 4'd1; end
      DIR_LEFT:  if (col != 4'd0) begin in_bounds = 1'b1; next_col = col - 4'd1; end
      DIR_RIGHT: if (col != 4'(GRID_W - 1)) begin in_bounds = 1'b1; next_col = col + 4'd1; end
      default:   in_bounds = 1'b0;
    endcase
    target = 7'(next_row) * 7'(GRID_W) + 7'(next_col);
    legal  = in_bounds && !maze[target];
  end

endmodule

// File: rtl/maze_run_sequencer.sv
// Launches the BFS solver under a watchdog, then replays its path one move at
// a time to a downstream consumer while tracking and checking the runner.
module maze_run_sequencer
  import maze_pkg::*;
#(
  parameter int STEP_GAP      = 4,
  parameter int SOLVE_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       abort,
  input  logic       maze [0:CELLS-1],
  output logic       bfs_start,
  input  logic [3:0] bfs_path [0:MAX_PATH-1],
  input  logic [6:0] bfs_path_length,
  input  logic       bfs_path_ready,
  input  logic       bfs_no_path,
  output logic       mv_valid,
  output logic [3:0] mv_dir,
  input  logic       mv_ready,
  output logic [6:0] pos,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] fail_code,
  output seq_state_t state_dbg
);

  seq_state_t state, state_n;
  fail_code_t fc;
  logic [3:0]  row, col, nrow, ncol, cur_dir;
  logic [6:0]  pos_q, idx, len;
  logic [15:0] wd;
  logic [7:0]  gap_cnt;
  logic        checked, chk_legal, wd_hit, gap_last, last_move;

  assign cur_dir   = bfs_path[idx];
  assign wd_hit    = ({1'b0, wd} + 17'd1) == 17'(SOLVE_TIMEOUT);
  assign gap_last  = gap_cnt == 8'(STEP_GAP - 1);
  assign last_move = (idx + 7'd1) == len;

  move_checker u_checker (
    .row      (row),
    .col      (col),
    .dir      (cur_dir),
    .maze     (maze),
    .legal    (chk_legal),
    .next_row (nrow),
    .next_col (ncol)
  );

  // Handshake: a move is offered only after its legality check cycle;
  // mv_valid and mv_dir then hold until an edge with mv_valid && mv_ready,
  // and only abort or reset may withdraw an offered move.
  always_comb begin
    state_n   = state;
    bfs_start = 1'b0;
    mv_valid  = 1'b0;
    case (state)
      S_IDLE:   if (go) state_n = S_LAUNCH;
      S_LAUNCH: begin
        bfs_start = 1'b1;
        state_n   = S_SOLVE;
      end
      S_SOLVE: begin
        if (bfs_no_path)         state_n = S_FAIL;
        else if (bfs_path_ready) state_n = (bfs_path_length != 7'd0) ? S_PLAY : S_DONE;
        else if (wd_hit)         state_n = S_FAIL;
      end
      S_PLAY: begin
        if (!checked) begin
          if (!chk_legal) state_n = S_FAIL;
        end else begin
          mv_valid = 1'b1;
          if (mv_ready) begin
            if (last_move)          state_n = S_DONE;
            else if (STEP_GAP == 0) state_n = S_PLAY;
            else                    state_n = S_GAP;
          end
        end
      end
      S_GAP:          if (gap_last) state_n = S_PLAY;
      S_DONE, S_FAIL: if (go) state_n = S_LAUNCH;
      default:        state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      row     <= 4'd0;
      col     <= 4'd0;
      pos_q   <= 7'd0;
      idx     <= 7'd0;
      len     <= 7'd0;
      wd      <= 16'd0;
      gap_cnt <= 8'd0;
      checked <= 1'b0;
      fc      <= FC_NONE;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          row <= 4'd0; col <= 4'd0; pos_q <= 7'd0; idx <= 7'd0;
          fc  <= FC_NONE;
        end
        S_LAUNCH: begin
          wd      <= 16'd0;
          checked <= 1'b0;
        end
        S_SOLVE: begin
          wd <= wd + 16'd1;
          if (bfs_no_path)         fc  <= FC_NO_PATH;
          else if (bfs_path_ready) len <= bfs_path_length;
          else if (wd_hit)         fc  <= FC_TIMEOUT;
        end
        S_PLAY: begin
          if (!checked) begin
            if (chk_legal) checked <= 1'b1;
            else           fc      <= FC_ILLEGAL;
          end else if (mv_ready) begin
            row     <= nrow;
            col     <= ncol;
            pos_q   <= 7'(nrow) * 7'(GRID_W) + 7'(ncol);
            idx     <= idx + 7'd1;
            checked <= 1'b0;
            gap_cnt <= 8'd0;
          end
        end
        S_GAP: gap_cnt <= gap_cnt + 8'd1;
        S_DONE, S_FAIL: begin
          if (go) begin
            row <= 4'd0; col <= 4'd0; pos_q <= 7'd0; idx <= 7'd0;
            fc  <= FC_NONE;
          end
        end
        default: ;
      endcase
      // Abort wins over any move or failure captured above on the same edge.
      if (abort) begin
        row <= 4'd0; col <= 4'd0; pos_q <= 7'd0; idx <= 7'd0;
        checked <= 1'b0;
        fc      <= FC_NONE;
      end
    end
  end

  always_comb begin
    busy      = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
    done      = state == S_DONE;
    fail      = state == S_FAIL;
    mv_dir    = mv_valid ? cur_dir : 4'd0;
    pos       = pos_q;
    fail_code = fc;
    state_dbg = state;
  end

endmodule

// File: tb/tb_maze_run_sequencer.sv
// Directed bench for maze_run_sequencer: moves are scoreboarded through an
// expected queue, and a second instance covers the solver watchdog.
module tb_maze_run_sequencer;
  import maze_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, go, abort, go_b;
  logic       maze [0:CELLS-1];
  logic [3:0] bfs_path [0:MAX_PATH-1];
  logic [6:0] bfs_path_length;
  logic       bfs_path_ready, bfs_no_path, mv_ready;

  logic       bfs_start, mv_valid, busy, done, fail;
  logic [3:0] mv_dir;
  logic [6:0] pos;
  logic [1:0] fail_code;
  seq_state_t state_dbg;

  logic       b_bfs_start, b_mv_valid, b_busy, b_done, b_fail;
  logic [3:0] b_mv_dir;
  logic [6:0] b_pos;
  logic [1:0] b_fail_code;
  seq_state_t b_state_dbg;

  maze_run_sequencer #(.STEP_GAP(4), .SOLVE_TIMEOUT(4096)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .maze(maze),
    .bfs_start(bfs_start), .bfs_path(bfs_path), .bfs_path_length(bfs_path_length),
    .bfs_path_ready(bfs_path_ready), .bfs_no_path(bfs_no_path),
    .mv_valid(mv_valid), .mv_dir(mv_dir), .mv_ready(mv_ready), .pos(pos),
    .busy(busy), .done(done), .fail(fail), .fail_code(fail_code), .state_dbg(state_dbg)
  );

  maze_run_sequencer #(.STEP_GAP(0), .SOLVE_TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .go(go_b), .abort(1'b0), .maze(maze),
    .bfs_start(b_bfs_start), .bfs_path(bfs_path), .bfs_path_length(bfs_path_length),
    .bfs_path_ready(1'b0), .bfs_no_path(1'b0),
    .mv_valid(b_mv_valid), .mv_dir(b_mv_dir), .mv_ready(1'b1), .pos(b_pos),
    .busy(b_busy), .done(b_done), .fail(b_fail), .fail_code(b_fail_code), .state_dbg(b_state_dbg)
  );

  logic [10:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_count = 0;
  int last_hs = 0;
  bit spacing_chk = 0, no_mv = 0, rand_rdy = 0;
  bit pend_pos = 0, prev_hold = 0;
  logic [6:0] exp_pos;
  logic [3:0] prev_dir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Move monitor: pops the expected queue on every handshake the DUT will see.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend_pos) begin
        check("pos_after_move", 32'(pos), 32'(exp_pos));
        pend_pos = 0;
      end
      if (prev_hold) begin
        check("hold_valid", 32'(mv_valid), 32'd1);
        check("hold_dir", 32'(mv_dir), 32'(prev_dir));
      end
      if (no_mv) check("no_move_offered", 32'(mv_valid), 32'd0);
      if (mv_valid && mv_ready && !abort) begin
        check("moves_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("move_dir", 32'(mv_dir), 32'(e[3:0]));
          exp_pos  = e[10:4];
          pend_pos = 1;
        end
        if (spacing_chk && hs_count > 0) check("move_period", 32'(cyc - last_hs), 32'd6);
        last_hs = cyc;
        hs_count++;
      end
      prev_hold = mv_valid && !mv_ready && !abort;
      prev_dir  = mv_dir;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) mv_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_end(input int max_cyc);
    int n;
    n = 0;
    while (!(done || fail) && n < max_cyc) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("end_within_budget", 32'(done || fail), 32'd1);
  endtask

  task automatic launch();
    go = 1'b1;
    tick();
    go = 1'b0;
    @(negedge clk);
    check("bfs_start_pulse", 32'(bfs_start), 32'd1);
    check("busy_launch", 32'(busy), 32'd1);
    check("done_cleared", 32'(done), 32'd0);
    check("fail_cleared", 32'(fail), 32'd0);
    check("fail_code_cleared", 32'(fail_code), 32'd0);
    check("pos_cleared", 32'(pos), 32'd0);
    tick();
    @(negedge clk);
    check("bfs_start_single", 32'(bfs_start), 32'd0);
  endtask

  task automatic solver_ok(input int delay, input logic [6:0] len);
    repeat (delay) begin
      tick();
      @(negedge clk);
    end
    bfs_path_length = len;
    bfs_path_ready  = 1'b1;
    tick();
    bfs_path_ready  = 1'b0;
  endtask

  // Reference walk of the programmed path from cell 0.
  task automatic push_moves(input int n);
    int r, c;
    r = 0;
    c = 0;
    for (int i = 0; i < n; i++) begin
      case (bfs_path[i])
        DIR_UP:    r--;
        DIR_DOWN:  r++;
        DIR_LEFT:  c--;
        DIR_RIGHT: c++;
        default: ;
      endcase
      exp_q.push_back({7'(r * 10 + c), bfs_path[i]});
    end
  endtask

  task automatic clear_world();
    for (int i = 0; i < CELLS; i++) maze[i] = 1'b0;
    for (int i = 0; i < MAX_PATH; i++) bfs_path[i] = DIR_RIGHT;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no end, expected summary");
    $fatal(1);
  end

  initial begin
    int hs0, n, first;
    bit aborted;
    rst_n = 1'b0; go = 1'b0; go_b = 1'b0; abort = 1'b0;
    bfs_path_ready = 1'b0; bfs_no_path = 1'b0; bfs_path_length = 7'd0;
    mv_ready = 1'b1;
    clear_world();
    repeat (3) tick();
    @(negedge clk);
    check("rst_bfs_start", 32'(bfs_start), 32'd0);
    check("rst_mv_valid", 32'(mv_valid), 32'd0);
    check("rst_mv_dir", 32'(mv_dir), 32'd0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_fail_code", 32'(fail_code), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Open maze, 9 RIGHT then 9 DOWN, consumer always ready.
    for (int i = 0; i < 18; i++) bfs_path[i] = (i < 9) ? DIR_RIGHT : DIR_DOWN;
    push_moves(18);
    hs0 = hs_count;
    spacing_chk = 1;
    launch();
    solver_ok(2, 7'd18);
    @(negedge clk);
    check("valid_at_m1", 32'(mv_valid), 32'd0);
    tick();
    @(negedge clk);
    check("valid_at_m2", 32'(mv_valid), 32'd1);
    check("first_dir", 32'(mv_dir), 32'(DIR_RIGHT));
    wait_end(300);
    spacing_chk = 0;
    check("run1_done", 32'(done), 32'd1);
    check("run1_fail", 32'(fail), 32'd0);
    check("run1_pos", 32'(pos), 32'd99);
    check("run1_busy", 32'(busy), 32'd0);
    check("run1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("run1_moves", 32'(hs_count - hs0), 32'd18);

    // Zero-length path straight to DONE, relaunched from DONE.
    no_mv = 1;
    launch();
    solver_ok(3, 7'd0);
    wait_end(20);
    check("len0_done", 32'(done), 32'd1);
    check("len0_pos", 32'(pos), 32'd0);

    // Solver reports no path 20 cycles after launch.
    launch();
    repeat (18) begin
      tick();
      @(negedge clk);
    end
    bfs_no_path = 1'b1;
    tick();
    bfs_no_path = 1'b0;
    wait_end(10);
    check("nopath_fail", 32'(fail), 32'd1);
    check("nopath_code", 32'(fail_code), 32'd1);
    check("nopath_done", 32'(done), 32'd0);

    // no_path and path_ready together: no_path wins.
    launch();
    bfs_path_length = 7'd5;
    bfs_path_ready = 1'b1;
    bfs_no_path = 1'b1;
    tick();
    bfs_path_ready = 1'b0;
    bfs_no_path = 1'b0;
    wait_end(10);
    check("both_code", 32'(fail_code), 32'd1);
    no_mv = 0;

    // Silent solver on the short-watchdog instance.
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    @(negedge clk);
    check("b_bfs_start", 32'(b_bfs_start), 32'd1);
    n = 0;
    first = 0;
    while (n < 40 && first == 0) begin
      tick();
      @(negedge clk);
      n++;
      if (b_fail) first = n;
    end
    check("timeout_cycles", 32'(first), 32'd17);
    check("timeout_code", 32'(b_fail_code), 32'd2);
    check("timeout_no_move", 32'(b_mv_valid), 32'd0);

    // Entry 3 steps into a wall; random consumer readiness.
    clear_world();
    bfs_path[0] = DIR_RIGHT; bfs_path[1] = DIR_RIGHT; bfs_path[2] = DIR_DOWN;
    bfs_path[3] = DIR_RIGHT; bfs_path[4] = DIR_RIGHT;
    maze[13] = 1'b1;
    push_moves(3);
    rand_rdy = 1;
    launch();
    solver_ok(1, 7'd5);
    wait_end(200);
    check("wall_fail", 32'(fail), 32'd1);
    check("wall_code", 32'(fail_code), 32'd3);
    check("wall_pos", 32'(pos), 32'd12);
    check("wall_valid", 32'(mv_valid), 32'd0);
    check("wall_queue_empty", 32'(exp_q.size()), 32'd0);

    // Entry 3 moves LEFT from column 0.
    clear_world();
    bfs_path[0] = DIR_DOWN; bfs_path[1] = DIR_DOWN; bfs_path[2] = DIR_DOWN;
    bfs_path[3] = DIR_LEFT;
    push_moves(3);
    launch();
    solver_ok(1, 7'd4);
    wait_end(200);
    check("edge_code", 32'(fail_code), 32'd3);
    check("edge_pos", 32'(pos), 32'd30);
    check("edge_queue_empty", 32'(exp_q.size()), 32'd0);

    // First entry not one-hot.
    bfs_path[0] = 4'b0011;
    launch();
    solver_ok(1, 7'd2);
    wait_end(20);
    check("onehot_code", 32'(fail_code), 32'd3);
    check("onehot_pos", 32'(pos), 32'd0);

    // Abort while a move is on offer.
    clear_world();
    for (int i = 0; i < 12; i++) bfs_path[i] = (i < 5) ? DIR_RIGHT : ((i < 10) ? DIR_DOWN : DIR_LEFT);
    push_moves(12);
    launch();
    solver_ok(1, 7'd12);
    hs0 = hs_count;
    aborted = 0;
    n = 0;
    while (n < 400 && !aborted) begin
      tick();
      if (hs_count - hs0 >= 5 && mv_valid) begin
        abort = 1'b1;
        mv_ready = 1'b1;
        aborted = 1;
      end
      @(negedge clk);
      n++;
    end
    check("abort_reached", 32'(aborted), 32'd1);
    rand_rdy = 0;
    tick();
    abort = 1'b0;
    mv_ready = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(state_dbg), 32'(S_IDLE));
    check("abort_pos", 32'(pos), 32'd0);
    check("abort_valid", 32'(mv_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    mv_ready = 1'b1;

    // Reset in the middle of a solve.
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_state", 32'(state_dbg), 32'(S_IDLE));
    check("midrst_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
